// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - shared ALU operation codes, divider state encoding and widths
package alu_exec_pkg;

    localparam int DATA_W = 32;

    typedef enum logic [4:0] {
        ALU_NONE  = 5'd0,
        ALU_AND   = 5'd1,
        ALU_OR    = 5'd2,
        ALU_XOR   = 5'd3,
        ALU_NOR   = 5'd4,
        ALU_LUI   = 5'd5,
        ALU_ADD   = 5'd6,
        ALU_ADDU  = 5'd7,
        ALU_SUB   = 5'd8,
        ALU_SUBU  = 5'd9,
        ALU_SLT   = 5'd10,
        ALU_SLTU  = 5'd11,
        ALU_SLL   = 5'd12,
        ALU_SRL   = 5'd13,
        ALU_SRA   = 5'd14,
        ALU_SLLV  = 5'd15,
        ALU_SRLV  = 5'd16,
        ALU_SRAV  = 5'd17,
        ALU_MFHI  = 5'd18,
        ALU_MFLO  = 5'd19,
        ALU_MTHI  = 5'd20,
        ALU_MTLO  = 5'd21,
        ALU_MULT  = 5'd22,
        ALU_MULTU = 5'd23,
        ALU_DIV   = 5'd24,
        ALU_DIVU  = 5'd25
    } alu_op_e;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/alu_exec_if.sv
// rtl/alu_exec_if.sv - EX-stage ALU bundle; master is the pipeline, slave is the ALU
interface alu_exec_if #(parameter int WIDTH = 32);
    logic             valid;
    logic             flush;
    logic [4:0]       alucontrol;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       sa;
    logic [WIDTH-1:0] hi_i;
    logic [WIDTH-1:0] lo_i;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             hilo_we;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             stall;

    modport master (
        output valid, flush, alucontrol, a, b, sa, hi_i, lo_i,
        input  result, overflow, hilo_we, hi_o, lo_o, stall
    );

    modport slave (
        input  valid, flush, alucontrol, a, b, sa, hi_i, lo_i,
        output result, overflow, hilo_we, hi_o, lo_o, stall
    );
endinterface

// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - iterative restoring divider, one quotient bit per cycle
module div_radix2
    import alu_exec_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              signed_op,
    input  logic              abort,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);
    div_state_e        r_state;
    logic [5:0]        r_cnt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_dvs;
    logic              r_neg_q;
    logic              r_neg_r;

    logic              w_a_neg;
    logic              w_b_neg;
    logic [DATA_W-1:0] w_a_abs;
    logic [DATA_W-1:0] w_b_abs;
    logic [DATA_W:0]   w_shift;
    logic              w_ge;
    logic [DATA_W-1:0] w_sub;

    assign w_a_neg = signed_op & dividend[DATA_W-1];
    assign w_b_neg = signed_op & divisor[DATA_W-1];
    assign w_a_abs = w_a_neg ? -dividend : dividend;
    assign w_b_abs = w_b_neg ? -divisor  : divisor;

    // Partial remainder never exceeds the divisor, so the difference fits in DATA_W bits.
    assign w_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_sub   = w_shift[DATA_W-1:0] - r_dvs;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (abort) begin
            r_state <= DIV_IDLE;
        end else begin
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        r_state <= DIV_BUSY;
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_quo   <= w_a_abs;
                        r_dvs   <= w_b_abs;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_r <= w_a_neg;
                    end
                end
                DIV_BUSY: begin
                    r_quo <= {r_quo[DATA_W-2:0], w_ge};
                    r_rem <= w_ge ? w_sub : w_shift[DATA_W-1:0];
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) begin
                        r_state <= DIV_DONE;
                    end
                end
                DIV_DONE: r_state <= DIV_IDLE;
                default:  r_state <= DIV_IDLE;
            endcase
        end
    end

    assign busy      = (r_state == DIV_BUSY);
    assign done      = (r_state == DIV_DONE);
    assign quotient  = r_neg_q ? -r_quo : r_quo;
    assign remainder = r_neg_r ? -r_rem : r_rem;
endmodule

// File: rtl/alu_exec.sv
// rtl/alu_exec.sv - execute-stage ALU with 1-cycle multiply and optional stalling divider
// ALU_DIV_EN builds the divider; without it DIV/DIVU write zero to HI/LO with no stall.
module alu_exec
    import alu_exec_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       resetn,
    alu_exec_if.slave  alu
);
    logic             w_gate;
    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic             w_add_ovf;
    logic             w_mul_signed;
    logic [63:0]      w_mul_a;
    logic [63:0]      w_mul_b;
    logic [63:0]      w_prod;
    logic [WIDTH-1:0] w_result;
    logic             w_ovf_raw;
    logic             w_we_raw;
    logic [WIDTH-1:0] w_hi;
    logic [WIDTH-1:0] w_lo;
    logic             w_stall;

    assign w_gate = alu.valid & ~alu.flush;

    // SUB reuses the adder as a + ~b + 1; the sign of ~b stands in for the sign of -b.
    assign w_is_sub  = (alu.alucontrol == ALU_SUB) || (alu.alucontrol == ALU_SUBU);
    assign w_b_eff   = w_is_sub ? ~alu.b : alu.b;
    assign w_sum     = alu.a + w_b_eff + {{(WIDTH-1){1'b0}}, w_is_sub};
    assign w_add_ovf = (alu.a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != alu.a[WIDTH-1]);

    assign w_mul_signed = (alu.alucontrol == ALU_MULT);
    assign w_mul_a      = {{32{w_mul_signed & alu.a[WIDTH-1]}}, alu.a};
    assign w_mul_b      = {{32{w_mul_signed & alu.b[WIDTH-1]}}, alu.b};
    assign w_prod       = w_mul_a * w_mul_b;

`ifdef ALU_DIV_EN
    logic             w_is_div;
    logic             w_div_start;
    logic             w_div_busy;
    logic             w_div_done;
    logic [WIDTH-1:0] w_div_quo;
    logic [WIDTH-1:0] w_div_rem;

    assign w_is_div    = (alu.alucontrol == ALU_DIV) || (alu.alucontrol == ALU_DIVU);
    assign w_div_start = w_gate & w_is_div & ~w_div_busy & ~w_div_done;

    div_radix2 u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (w_div_start),
        .signed_op (alu.alucontrol == ALU_DIV),
        .abort     (alu.flush),
        .dividend  (alu.a),
        .divisor   (alu.b),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );

    // Stall from the start cycle through the last iteration; DONE lets the instruction leave.
    assign w_stall = w_gate & (w_div_busy | (w_is_div & ~w_div_done));
`else
    logic w_unused;
    assign w_unused = &{1'b0, clk, resetn};
    assign w_stall  = 1'b0;
`endif

    always_comb begin
        w_result  = '0;
        w_ovf_raw = 1'b0;
        w_we_raw  = 1'b0;
        w_hi      = alu.hi_i;
        w_lo      = alu.lo_i;
        case (alu.alucontrol)
            ALU_AND:  w_result = alu.a & alu.b;
            ALU_OR:   w_result = alu.a | alu.b;
            ALU_XOR:  w_result = alu.a ^ alu.b;
            ALU_NOR:  w_result = ~(alu.a | alu.b);
            ALU_LUI:  w_result = {alu.b[15:0], 16'h0000};
            ALU_ADD, ALU_SUB: begin
                w_result  = w_sum;
                w_ovf_raw = w_add_ovf;
            end
            ALU_ADDU, ALU_SUBU: w_result = w_sum;
            ALU_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(alu.a) < $signed(alu.b))};
            ALU_SLTU: w_result = {{(WIDTH-1){1'b0}}, (alu.a < alu.b)};
            ALU_SLL:  w_result = alu.b << alu.sa;
            ALU_SRL:  w_result = alu.b >> alu.sa;
            ALU_SRA:  w_result = $unsigned($signed(alu.b) >>> alu.sa);
            ALU_SLLV: w_result = alu.b << alu.a[4:0];
            ALU_SRLV: w_result = alu.b >> alu.a[4:0];
            ALU_SRAV: w_result = $unsigned($signed(alu.b) >>> alu.a[4:0]);
            ALU_MFHI: w_result = alu.hi_i;
            ALU_MFLO: w_result = alu.lo_i;
            ALU_MTHI: begin
                w_we_raw = 1'b1;
                w_hi     = alu.a;
            end
            ALU_MTLO: begin
                w_we_raw = 1'b1;
                w_lo     = alu.a;
            end
            ALU_MULT, ALU_MULTU: begin
                w_we_raw = 1'b1;
                w_hi     = w_prod[63:32];
                w_lo     = w_prod[31:0];
            end
            ALU_DIV, ALU_DIVU: begin
`ifdef ALU_DIV_EN
                w_we_raw = w_div_done;
                w_hi     = w_div_rem;
                w_lo     = w_div_quo;
`else
                w_we_raw = 1'b1;
                w_hi     = '0;
                w_lo     = '0;
`endif
            end
            default: ;
        endcase
    end

    assign alu.result   = w_result;
    assign alu.overflow = w_gate & w_ovf_raw;
    assign alu.hilo_we  = w_gate & w_we_raw;
    assign alu.hi_o     = w_hi;
    assign alu.lo_o     = w_lo;
    assign alu.stall    = w_stall;
endmodule

// File: tb/tb_alu_exec.sv
// tb/tb_alu_exec.sv - table-driven ALU vectors plus divider latency/abort sequences
module tb_alu_exec;
    import alu_exec_pkg::*;

    localparam logic [31:0] H = 32'h1111_1111;
    localparam logic [31:0] L = 32'h2222_2222;

    typedef struct {
        string       name;
        logic        v;
        logic        f;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sa;
        logic [31:0] r;
        logic        cr;
        logic        ovf;
        logic        we;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    logic clk;
    logic resetn;
    int   n_assert;
    int   n_fail;
    vec_t tbl[$];

    alu_exec_if dif();

    alu_exec dut (
        .clk    (clk),
        .resetn (resetn),
        .alu    (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic push_vec(input string nm, input logic v, input logic f, input logic [4:0] op,
                            input logic [31:0] a, input logic [31:0] b, input logic [4:0] sa,
                            input logic [31:0] r, input logic cr, input logic ovf,
                            input logic we, input logic [31:0] hi, input logic [31:0] lo);
        vec_t t;
        t.name = nm; t.v = v; t.f = f; t.op = op; t.a = a; t.b = b; t.sa = sa;
        t.r = r; t.cr = cr; t.ovf = ovf; t.we = we; t.hi = hi; t.lo = lo;
        tbl.push_back(t);
    endtask

    task automatic drive(input logic v, input logic f, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        dif.valid      = v;
        dif.flush      = f;
        dif.alucontrol = op;
        dif.a          = a;
        dif.b          = b;
    endtask

    // Starts a division at the current cycle (just after a rising edge) and follows it to DONE.
    task automatic div_op(input string nm, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] e_lo, input logic [31:0] e_hi);
        int          sc;
        int          wc;
        int          k;
        bit          fin;
        logic [31:0] rlo;
        logic [31:0] rhi;
        sc = 0; wc = 0; k = 0; fin = 0; rlo = '0; rhi = '0;
        drive(1'b1, 1'b0, op, a, b);
        while (!fin && k < 60) begin
            @(negedge clk);
            if (dif.hilo_we) begin
                wc++;
                rlo = dif.lo_o;
                rhi = dif.hi_o;
            end
            if (dif.stall) sc++;
            else fin = 1;
            if (!fin) begin
                @(posedge clk); #1;
            end
            k++;
        end
        chk1({nm, ".finished"}, fin, 1'b1);
        chk32({nm, ".stall_cycles"}, sc, 32'd33);
        chk32({nm, ".we_cycles"}, wc, 32'd1);
        chk32({nm, ".lo"}, rlo, e_lo);
        chk32({nm, ".hi"}, rhi, e_hi);
        @(posedge clk); #1;
    endtask

    // DIV -7/2 aborted at T<t_abort> by flush or by reset, then a clean DIVU 9/4.
    task automatic abort_seq(input string nm, input bit use_reset, input int t_abort);
        int ws;
        int ss;
        ws = 0; ss = 0;
        drive(1'b1, 1'b0, ALU_DIV, 32'hFFFF_FFF9, 32'd2);
        for (int k = 0; k < t_abort; k++) begin
            @(negedge clk);
            if (dif.hilo_we) ws++;
            @(posedge clk); #1;
        end
        if (use_reset) begin
            resetn    = 1'b0;
            dif.valid = 1'b0;
        end else begin
            dif.flush = 1'b1;
        end
        @(negedge clk);
        if (dif.hilo_we) ws++;
        @(posedge clk); #1;
        resetn = 1'b1;
        drive(1'b1, 1'b0, ALU_ADDU, 32'd1, 32'd2);
        @(negedge clk);
        chk1({nm, ".stall_after_abort"}, dif.stall, 1'b0);
        chk32({nm, ".next_result"}, dif.result, 32'd3);
        for (int k = 0; k < 35; k++) begin
            if (dif.hilo_we) ws++;
            if (dif.stall) ss++;
            @(negedge clk);
        end
        chk32({nm, ".hilo_we_seen"}, ws, 32'd0);
        chk32({nm, ".stall_seen"}, ss, 32'd0);
        @(posedge clk); #1;
        div_op({nm, ".divu_9_4"}, ALU_DIVU, 32'd9, 32'd4, 32'd2, 32'd1);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        drive(1'b0, 1'b0, ALU_NONE, '0, '0);
        dif.sa   = '0;
        dif.hi_i = H;
        dif.lo_i = L;

        //        name        v     f     op         a              b              sa     result         cr    ovf   we    hi             lo
        push_vec("none",     1'b1, 1'b0, ALU_NONE,  32'd5,         32'd6,         5'd0,  32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("and",      1'b1, 1'b0, ALU_AND,   32'hF0F0F0F0,  32'hFF00FF00,  5'd0,  32'hF000F000,  1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("or",       1'b1, 1'b0, ALU_OR,    32'hF0F0F0F0,  32'hFF00FF00,  5'd0,  32'hFFF0FFF0,  1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("xor",      1'b1, 1'b0, ALU_XOR,   32'hF0F0F0F0,  32'hFF00FF00,  5'd0,  32'h0FF00FF0,  1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("nor",      1'b1, 1'b0, ALU_NOR,   32'hF0F0F0F0,  32'hFF00FF00,  5'd0,  32'h000F000F,  1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("lui",      1'b1, 1'b0, ALU_LUI,   32'h0,         32'h1234ABCD,  5'd0,  32'hABCD0000,  1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("add_ovf",  1'b1, 1'b0, ALU_ADD,   32'h7FFFFFFF,  32'd1,         5'd0,  32'h80000000,  1'b1, 1'b1, 1'b0, 32'h0,         32'h0);
        push_vec("addu",     1'b1, 1'b0, ALU_ADDU,  32'h7FFFFFFF,  32'd1,         5'd0,  32'h80000000,  1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("add_inv",  1'b0, 1'b0, ALU_ADD,   32'h7FFFFFFF,  32'd1,         5'd0,  32'h80000000,  1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("sub_ovf",  1'b1, 1'b0, ALU_SUB,   32'h80000000,  32'd1,         5'd0,  32'h7FFFFFFF,  1'b1, 1'b1, 1'b0, 32'h0,         32'h0);
        push_vec("sub_neg",  1'b1, 1'b0, ALU_SUB,   32'd5,         32'd7,         5'd0,  32'hFFFFFFFE,  1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("subu",     1'b1, 1'b0, ALU_SUBU,  32'h80000000,  32'd1,         5'd0,  32'h7FFFFFFF,  1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("slt_0",    1'b1, 1'b0, ALU_SLT,   32'd1,         32'hFFFFFFFF,  5'd0,  32'd0,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("sltu_1",   1'b1, 1'b0, ALU_SLTU,  32'd1,         32'hFFFFFFFF,  5'd0,  32'd1,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("slt_1",    1'b1, 1'b0, ALU_SLT,   32'hFFFFFFFF,  32'd1,         5'd0,  32'd1,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("sll",      1'b1, 1'b0, ALU_SLL,   32'h0,         32'd1,         5'd31, 32'h80000000,  1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("srl",      1'b1, 1'b0, ALU_SRL,   32'h0,         32'h80000000,  5'd4,  32'h08000000,  1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("sra",      1'b1, 1'b0, ALU_SRA,   32'h0,         32'h80000000,  5'd4,  32'hF8000000,  1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("sllv",     1'b1, 1'b0, ALU_SLLV,  32'h24,        32'h0000000F,  5'd9,  32'h000000F0,  1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("srlv",     1'b1, 1'b0, ALU_SRLV,  32'h8,         32'hFF000000,  5'd1,  32'h00FF0000,  1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("srav",     1'b1, 1'b0, ALU_SRAV,  32'hFFFFFFE1,  32'h80000000,  5'd7,  32'hC0000000,  1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("mfhi",     1'b1, 1'b0, ALU_MFHI,  32'h0,         32'h0,         5'd0,  H,             1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("mflo",     1'b1, 1'b0, ALU_MFLO,  32'h0,         32'h0,         5'd0,  L,             1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("mthi",     1'b1, 1'b0, ALU_MTHI,  32'hDEADBEEF,  32'h0,         5'd0,  32'h0,         1'b0, 1'b0, 1'b1, 32'hDEADBEEF,  L);
        push_vec("mtlo",     1'b1, 1'b0, ALU_MTLO,  32'hDEADBEEF,  32'h0,         5'd0,  32'h0,         1'b0, 1'b0, 1'b1, H,             32'hDEADBEEF);
        push_vec("mthi_fl",  1'b1, 1'b1, ALU_MTHI,  32'hDEADBEEF,  32'h0,         5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0);
        push_vec("mult",     1'b1, 1'b0, ALU_MULT,  32'hFFFFFFFD,  32'd5,         5'd0,  32'h0,         1'b0, 1'b0, 1'b1, 32'hFFFFFFFF,  32'hFFFFFFF1);
        push_vec("multu",    1'b1, 1'b0, ALU_MULTU, 32'hFFFFFFFF,  32'd2,         5'd0,  32'h0,         1'b0, 1'b0, 1'b1, 32'h00000001,  32'hFFFFFFFE);
        push_vec("unlisted", 1'b1, 1'b0, 5'd31,     32'hFFFFFFFF,  32'hFFFFFFFF,  5'd3,  32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         32'h0);
`ifndef ALU_DIV_EN
        push_vec("div_nodiv", 1'b1, 1'b0, ALU_DIV,  32'd7,         32'd2,         5'd0,  32'h0,         1'b0, 1'b0, 1'b1, 32'h0,         32'h0);
        push_vec("divu_fl",   1'b1, 1'b1, ALU_DIVU, 32'd7,         32'd2,         5'd0,  32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         32'h0);
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("reset.stall", dif.stall, 1'b0);
        chk1("reset.hilo_we", dif.hilo_we, 1'b0);
        @(posedge clk); #1;
        resetn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk); #1;
            drive(tbl[i].v, tbl[i].f, tbl[i].op, tbl[i].a, tbl[i].b);
            dif.sa = tbl[i].sa;
            @(negedge clk);
            if (tbl[i].cr) chk32({tbl[i].name, ".result"}, dif.result, tbl[i].r);
            chk1({tbl[i].name, ".overflow"}, dif.overflow, tbl[i].ovf);
            chk1({tbl[i].name, ".hilo_we"}, dif.hilo_we, tbl[i].we);
            chk1({tbl[i].name, ".stall"}, dif.stall, 1'b0);
            if (tbl[i].we) begin
                chk32({tbl[i].name, ".hi_o"}, dif.hi_o, tbl[i].hi);
                chk32({tbl[i].name, ".lo_o"}, dif.lo_o, tbl[i].lo);
            end
        end

`ifdef ALU_DIV_EN
        @(posedge clk); #1;
        div_op("div_m7_2", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        div_op("divu_100_0", ALU_DIVU, 32'd100, 32'd0, 32'hFFFF_FFFF, 32'd100);
        div_op("div_min_m1", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
        div_op("div_7_m2", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1);
        drive(1'b0, 1'b0, ALU_NONE, '0, '0);
        @(negedge clk);
        chk1("div_after.hilo_we", dif.hilo_we, 1'b0);
        @(posedge clk); #1;
        abort_seq("flush_t10", 1'b0, 10);
        abort_seq("reset_t5", 1'b1, 5);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
